urv_mulh_seq: RTL

//  Iterative 32x32->64 multiplier; sits beside the single-cycle low-product

---
 rtl/urv_mulh_seq.sv | 113 +++++++++++
 1 files changed

// File: rtl/urv_mulh_seq.sv
// Iterative 32x32->64 multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Operands are reduced to magnitudes, multiplied G bits per cycle, then sign-corrected.
module urv_mulh_seq #(
   parameter int G_BITS_PER_CYCLE = 1
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        start_i,
   input  logic        kill_i,
   input  logic [31:0] d_rs1_i,
   input  logic [31:0] d_rs2_i,
   input  logic [2:0]  d_fun_i,
   output logic        busy_o,
   output logic        stall_req_o,
   output logic        valid_o,
   output logic [31:0] result_o
);

   // state | meaning
   // IDLE  | waiting for start_i; operands latched on accept
   // CALC  | N shift-add iterations on magnitudes, counter N-1..0
   // FIXUP | negate the 64-bit product if the signs differ
   // DONE  | valid_o pulse, result word presented and held
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CALC  = 2'd1,
      S_FIXUP = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam int G = G_BITS_PER_CYCLE;
   localparam int N = 32 / G;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q;
   logic [63:0] p_q;
   logic [31:0] m_q;
   logic        neg_q;
   logic [2:0]  fun_q;
   logic [31:0] result_q;

   logic        accept;
   logic        s1, s2;
   logic [31:0] mag1, mag2;
   logic [31+G:0] hi;

   assign accept = (state_q == S_IDLE) && start_i && !kill_i;
   assign s1     = (d_fun_i == 3'b001) || (d_fun_i == 3'b010);
   assign s2     = (d_fun_i == 3'b001);
   // 0x80000000 negates to itself, which reads correctly as 2^31 unsigned
   assign mag1   = (s1 && d_rs1_i[31]) ? (~d_rs1_i + 32'd1) : d_rs1_i;
   assign mag2   = (s2 && d_rs2_i[31]) ? (~d_rs2_i + 32'd1) : d_rs2_i;

   assign hi = {{G{1'b0}}, p_q[63:32]} +
               ({{G{1'b0}}, m_q} * {{32{1'b0}}, p_q[G-1:0]});

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = S_CALC;
         S_CALC: begin
            if (kill_i)              state_d = S_IDLE;
            else if (cnt_q == 5'd0)  state_d = S_FIXUP;
         end
         S_FIXUP: state_d = kill_i ? S_IDLE : S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign busy_o      = (state_q != S_IDLE);
   assign stall_req_o = busy_o || (start_i && !kill_i);
   assign valid_o     = (state_q == S_DONE) && !kill_i;
   // a killed DONE never reaches result_o, so the held word stays from the last good op
   assign result_o    = valid_o ? ((fun_q == 3'b000) ? p_q[31:0] : p_q[63:32]) : result_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= S_IDLE;
         cnt_q    <= 5'd0;
         p_q      <= 64'd0;
         m_q      <= 32'd0;
         neg_q    <= 1'b0;
         fun_q    <= 3'd0;
         result_q <= 32'd0;
      end else begin
         state_q <= state_d;
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  fun_q <= d_fun_i;
                  neg_q <= (s1 & d_rs1_i[31]) ^ (s2 & d_rs2_i[31]);
                  m_q   <= mag1;
                  p_q   <= {32'd0, mag2};
                  cnt_q <= 5'(N - 1);
               end
            end
            S_CALC: begin
               p_q   <= {hi, p_q[31:G]};
               cnt_q <= cnt_q - 5'd1;
            end
            S_FIXUP: begin
               if (neg_q) p_q <= ~p_q + 64'd1;
            end
            S_DONE: begin
               if (valid_o) result_q <= result_o;
            end
            default: ;
         endcase
      end
   end

endmodule
